// File: rtl/mar_pkg.sv
// Shared width, type and reset constants for the memory address register.
// Optional bounds checking in the top is enabled by MAR_BOUNDS_CHECK_EN.
package mar_pkg;

  localparam int unsigned MAR_ADDR_W = 16;

  typedef logic [MAR_ADDR_W-1:0] mar_addr_t;

  localparam mar_addr_t MAR_RESET_ADDR = '0;

endpackage : mar_pkg

// File: rtl/mar_range_check.sv
// Combinational legal-window compare for an address; the caller registers the result.
// Instantiated only when MAR_BOUNDS_CHECK_EN is defined.
module mar_range_check #(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   FAULT_LO = '0,
  parameter logic [ADDR_W-1:0]   FAULT_HI = '1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              out_of_range_c
);

  // An inverted window (LO > HI) makes every address fault, which falls out naturally here.
  always_comb begin
    out_of_range_c = 1'b0;
    if ((addr < FAULT_LO) || (addr > FAULT_HI)) begin
      out_of_range_c = 1'b1;
    end
  end

endmodule : mar_range_check

// File: rtl/memory_access_reg.sv
// Memory address register: captures the address source every rising edge and drives memory.
// Define MAR_BOUNDS_CHECK_EN to add the registered addr_fault out-of-range flag.
module memory_access_reg
  import mar_pkg::*;
#(
  parameter int unsigned       ADDR_W     = MAR_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(MAR_RESET_ADDR)
`ifdef MAR_BOUNDS_CHECK_EN
  ,
  parameter logic [ADDR_W-1:0] FAULT_LO   = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] FAULT_HI   = ADDR_W'(16'hFFFF)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_input,
  output logic [ADDR_W-1:0] address_output
`ifdef MAR_BOUNDS_CHECK_EN
  ,
  output logic              addr_fault
`endif
);

  // Address register: loads every cycle, no enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_output <= RESET_ADDR;
    end else begin
      address_output <= address_input;
    end
  end

`ifdef MAR_BOUNDS_CHECK_EN
  logic out_of_range_c;

  mar_range_check #(
    .ADDR_W   (ADDR_W),
    .FAULT_LO (FAULT_LO),
    .FAULT_HI (FAULT_HI)
  ) u_range_check (
    .addr           (address_input),
    .out_of_range_c (out_of_range_c)
  );

  // Advisory flag registered alongside the address it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_fault <= 1'b0;
    end else begin
      addr_fault <= out_of_range_c;
    end
  end
`endif

endmodule : memory_access_reg

// File: tb/tb_memory_access_reg.sv
// Self-checking bench for memory_access_reg: directed scenarios plus randomized traffic.
// Build with MAR_BOUNDS_CHECK_EN defined to also exercise addr_fault.
module tb_memory_access_reg;
  import mar_pkg::*;

  localparam mar_addr_t RST_A = 16'h0000;
  localparam mar_addr_t LO    = 16'h0100;
  localparam mar_addr_t HI    = 16'h7FFF;

  logic      clk;
  logic      reset;
  mar_addr_t address_input;
  mar_addr_t address_output;
`ifdef MAR_BOUNDS_CHECK_EN
  logic      addr_fault;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the output is whatever was presented at the last clean edge.
  mar_addr_t exp_addr;
  logic      exp_fault;

`ifdef MAR_BOUNDS_CHECK_EN
  memory_access_reg #(
    .ADDR_W     (16),
    .RESET_ADDR (RST_A),
    .FAULT_LO   (LO),
    .FAULT_HI   (HI)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address_input  (address_input),
    .address_output (address_output),
    .addr_fault     (addr_fault)
  );
`else
  memory_access_reg #(
    .ADDR_W     (16),
    .RESET_ADDR (RST_A)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address_input  (address_input),
    .address_output (address_output)
  );
`endif

  function automatic logic model_fault(input mar_addr_t a);
    return (int'(a) < int'(LO)) || (int'(a) > int'(HI));
  endfunction

  task automatic check_addr(input string tag, input mar_addr_t obs, input mar_addr_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_addr(tag, address_output, exp_addr);
`ifdef MAR_BOUNDS_CHECK_EN
    check_bit({tag, "_fault"}, addr_fault, exp_fault);
`endif
  endtask

  // One full clock period; model updates at the rising edge, checks happen with clk low.
  task automatic tick();
    #5 clk = 1'b1;
    if (reset) begin
      exp_addr  = RST_A;
      exp_fault = 1'b0;
    end else begin
      exp_addr  = address_input;
      exp_fault = model_fault(address_input);
    end
    #5 clk = 1'b0;
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b1;
    exp_addr  = RST_A;
    exp_fault = 1'b0;
    #1 check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    mar_addr_t corners [3];
    corners[0] = 16'hFFFF;
    corners[1] = 16'h0000;
    corners[2] = 16'hA5A5;

    // Power-up reset with clock held low
    clk           = 1'b0;
    reset         = 1'b1;
    address_input = 16'h1234;
    exp_addr      = RST_A;
    exp_fault     = 1'b0;
    #3 check_all("power_up_reset");

    // First capture, then hold for 10 cycles
    reset = 1'b0;
    #2 tick();
    check_all("first_capture");
    check_addr("first_capture_value", address_output, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_addr("hold_1234", address_output, 16'h1234);
    end

    // Input change between edges is invisible until the next rise
    #2 address_input = 16'h5678;
    #1 check_addr("change_before_edge", address_output, 16'h1234);
    #2 clk = 1'b1;
    #1 check_addr("after_rise", address_output, 16'h5678);
    exp_addr  = 16'h5678;
    exp_fault = model_fault(16'h5678);
    #4 clk = 1'b0;
    #1 check_addr("after_fall", address_output, 16'h5678);
    #4;

    // Async reset mid-run, then reload current input
    async_reset_pulse("async_reset_mid_run");
    address_input = 16'h2BCD;
    tick();
    check_addr("reload_after_reset", address_output, 16'h2BCD);

    // Back-to-back corner values
    for (int i = 0; i < 3; i++) begin
      address_input = corners[i];
      tick();
      check_all("corner_value");
      check_bit("corner_no_x", $isunknown(address_output), 1'b0);
    end

    // Reset asserted in the same time step as a rising edge
    #5 reset = 1'b1;
    clk = 1'b1;
    exp_addr  = RST_A;
    exp_fault = 1'b0;
    #1 check_all("reset_with_edge");
    #4 clk = 1'b0;
    reset = 1'b0;

`ifdef MAR_BOUNDS_CHECK_EN
    // Window boundaries around LO and HI
    address_input = 16'h00FF; tick();
    check_bit("bounds_00FF", addr_fault, 1'b1);
    check_addr("bounds_00FF_addr", address_output, 16'h00FF);
    address_input = 16'h0100; tick();
    check_bit("bounds_0100", addr_fault, 1'b0);
    address_input = 16'h7FFF; tick();
    check_bit("bounds_7FFF", addr_fault, 1'b0);
    address_input = 16'h8000; tick();
    check_bit("bounds_8000", addr_fault, 1'b1);
    check_addr("bounds_8000_addr", address_output, 16'h8000);
`endif

    // Randomized traffic with occasional mid-cycle async resets
    for (int i = 0; i < 200; i++) begin
      address_input = 16'($urandom);
      if (($urandom % 16) == 0) begin
        async_reset_pulse("random_async_reset");
        #7;
        check_all("random_held_in_reset_gap");
      end else begin
        tick();
        check_all("random_capture");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memory_access_reg
